// File: rtl/rv_instr_encoder_if.sv
// Request and instruction-memory write channels of the RV32I instruction encoder.
// The master modport is the requester/memory side; the slave modport is the encoder.
interface rv_instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [12:0]       req_imm;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    input  req_ready,
    input  mem_wvalid, mem_waddr, mem_wdata,
    output mem_wready
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    output req_ready,
    output mem_wvalid, mem_waddr, mem_wdata,
    input  mem_wready
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Encodes LOAD/STORE/BRANCH/R-TYPE field requests into RV32I words and streams them
// into instruction memory at consecutive word addresses, one registered word in flight.
module rv_instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  rv_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic [1:0] KIND_LOAD   = 2'b00;
  localparam logic [1:0] KIND_STORE  = 2'b01;
  localparam logic [1:0] KIND_BRANCH = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              wvalid_q, wvalid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              ready_c;
  logic              accept_c;
  logic              legal_c;
  logic [31:0]       enc_c;

  // Start always wins, so a same-cycle request is never handshaken.
  assign ready_c  = (state_q == RUN) && (count_q < DEPTH_C) &&
                    (!wvalid_q || bus.mem_wready) && !start;
  assign accept_c = bus.req_valid && ready_c;

  // Instruction formatting and immediate legality check.
  always_comb begin
    enc_c   = '0;
    legal_c = 1'b1;
    case (bus.req_kind)
      KIND_LOAD: begin
        enc_c   = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_LOAD};
        legal_c = (bus.req_imm[12] == bus.req_imm[11]);
      end
      KIND_STORE: begin
        enc_c   = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                   bus.req_imm[4:0], OP_STORE};
        legal_c = (bus.req_imm[12] == bus.req_imm[11]);
      end
      KIND_BRANCH: begin
        enc_c   = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                   bus.req_imm[4:1], bus.req_imm[11], OP_BRANCH};
        legal_c = (bus.req_imm[0] == 1'b0);
      end
      default: begin
        enc_c   = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd, OP_RTYPE};
        legal_c = 1'b1;
      end
    endcase
  end

  // Next-state: output slot drains on mem_wready and is refilled by a legal accept.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    wvalid_d = wvalid_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (start) begin
      state_d  = RUN;
      count_d  = '0;
      err_d    = 1'b0;
      wvalid_d = 1'b0;
    end else begin
      if (wvalid_q && bus.mem_wready) begin
        wvalid_d = 1'b0;
      end
      if (accept_c) begin
        if (legal_c) begin
          wvalid_d = 1'b1;
          waddr_d  = count_q[ADDR_W-1:0];
          wdata_d  = enc_c;
          count_d  = count_q + ONE_C;
          if (count_d == DEPTH_C) begin
            state_d = FULL;
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
      wvalid_q <= wvalid_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.mem_wvalid = wvalid_q;
  assign bus.mem_waddr  = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign count          = count_q;
  assign full           = full_q;
  assign err            = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: expected writes are queued as requests are driven
// and matched against the memory-side handshakes captured by a monitor.
module tb_rv_instr_encoder;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  rv_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  rv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  int                n_cmp = 0;
  int                n_fail = 0;
  longint            cyc = 0;
  wr_t               exp_q[$];
  wr_t               got_q[$];
  longint            got_cyc[$];
  logic [ADDR_W-1:0] exp_ptr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture completed memory handshakes; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.mem_wvalid === 1'b1 && bus.mem_wready === 1'b1) begin
      got_q.push_back({bus.mem_waddr, bus.mem_wdata});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] model_enc(input logic [1:0] k, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [12:0] imm);
    case (k)
      2'd0:    return {imm[11:0], rs1, f3, rd, 7'b0000011};
      2'd1:    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      2'd2:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      default: return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] k, input logic [12:0] imm);
    if (k == 2'd0 || k == 2'd1) return imm[12] == imm[11];
    if (k == 2'd2) return imm[0] == 1'b0;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm);
    bus.req_kind   = k;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_funct3 = f3;
    bus.req_funct7 = f7;
    bus.req_imm    = imm;
  endtask

  // Drive one request until handshaken; queue its expected write when legal.
  task automatic do_req(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [12:0] imm,
      output bit acc);
    acc = 1'b0;
    set_req(k, rd, rs1, rs2, f3, f7, imm);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_accept_timeout: req_ready never 1 within 40 cycles (kind=%0d)", k);
    end else if (model_legal(k, imm)) begin
      exp_q.push_back({exp_ptr, model_enc(k, rd, rs1, rs2, f3, f7, imm)});
      exp_ptr++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    exp_q.delete();
    exp_ptr = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.req_valid = 1'b0; bus.mem_wready = 1'b0;
    set_req(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    #2;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b want 0", bus.mem_wvalid); end
    n_cmp++; if (bus.mem_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", bus.mem_waddr); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    n_cmp++; if (count !== '0 || full !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got count=%0d full=%b err=%b want 0/0/0", count, full, err); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_req_ready: got %b want 0", bus.req_ready); end
  endtask

  task automatic test_encode();
    bit acc;
    wr_t g, e;
    pulse_start();
    bus.mem_wready = 1'b1;
    do_req(2'd0, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'h1FFC, acc);
    idle(2);
    n_cmp++; if (count !== 11'd1) begin n_fail++; $display("FAIL load_count: got %0d want 1", count); end
    do_req(2'd1, 5'd0, 5'd3, 5'd7, 3'b010, 7'd0, 13'd8, acc);
    idle(2);
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL encode_nwrites: got %0d want 2", got_q.size());
    end else begin
      n_cmp++; if (got_q[0] !== {10'd0, 32'hFFC12283}) begin n_fail++;
        $display("FAIL load_word: got addr=%0d data=%h want addr=0 data=ffc12283", got_q[0].addr, got_q[0].data); end
      n_cmp++; if (got_q[1] !== {10'd1, 32'h0071A423}) begin n_fail++;
        $display("FAIL store_word: got addr=%0d data=%h want addr=1 data=0071a423", got_q[1].addr, got_q[1].data); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL sb_missing: no write, want addr=%0d data=%h", e.addr, e.data);
      end else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_fail++; $display("FAIL sb_encode: got addr=%0d data=%h want addr=%0d data=%h", g.addr, g.data, e.addr, e.data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    wr_t g, e;
    longint c0;
    bus.mem_wready = 1'b1;
    set_req(2'd2, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 13'd16);
    bus.req_valid = 1'b1;
    exp_q.push_back({exp_ptr, 32'h00208863}); exp_ptr++;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    set_req(2'd3, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 13'd0);
    exp_q.push_back({exp_ptr, 32'h402081B3}); exp_ptr++;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    idle(2);
    n_cmp++; if (got_cyc.size() != 2 || got_cyc[1] - got_cyc[0] != 1) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d writes, want 2 on consecutive cycles", got_cyc.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL sb_missing: no write, want addr=%0d data=%h", e.addr, e.data);
      end else begin
        g = got_q.pop_front(); c0 = got_cyc.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL sb_b2b: got addr=%0d data=%h want addr=%0d data=%h", g.addr, g.data, e.addr, e.data); end
      end
    end
    n_cmp++; if (count !== 11'd4 || full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got count=%0d full=%b want 4/1", count, full); end
    bus.req_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_illegal();
    bit acc;
    wr_t g, e;
    pulse_start();
    bus.mem_wready = 1'b1;
    do_req(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3, acc);
    n_cmp++; if (!acc) begin n_fail++; $display("FAIL ill_branch_hs: got no handshake want handshake"); end
    idle(2);
    n_cmp++; if (bus.mem_wvalid !== 1'b0 || err !== 1'b1 || count !== '0) begin
      n_fail++; $display("FAIL ill_branch: got wvalid=%b err=%b count=%0d want 0/1/0", bus.mem_wvalid, err, count); end
    pulse_start();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL start_clr_err: got %b want 0", err); end
    do_req(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'h0800, acc);
    idle(2);
    n_cmp++; if (bus.mem_wvalid !== 1'b0 || err !== 1'b1 || count !== '0) begin
      n_fail++; $display("FAIL ill_load: got wvalid=%b err=%b count=%0d want 0/1/0", bus.mem_wvalid, err, count); end
    // Most negative 12-bit offset is still legal and keeps err sticky.
    do_req(2'd0, 5'd4, 5'd6, 5'd0, 3'b011, 7'd0, 13'h1800, acc);
    idle(2);
    n_cmp++; if (count !== 11'd1 || err !== 1'b1) begin n_fail++; $display("FAIL edge_load: got count=%0d err=%b want 1/1", count, err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL sb_missing: no write, want addr=%0d data=%h", e.addr, e.data);
      end else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_fail++; $display("FAIL sb_illegal: got addr=%0d data=%h want addr=%0d data=%h", g.addr, g.data, e.addr, e.data); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL sb_extra: got %0d extra writes want 0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    bit acc;
    wr_t g, e, first;
    logic [1:0] k[4];
    logic [12:0] imm[4];
    logic [4:0] r[4];
    for (int i = 0; i < 4; i++) begin
      k[i] = 2'($urandom_range(0, 3));
      imm[i] = 13'($urandom);
      r[i] = 5'($urandom);
      if (k[i] == 2'd0 || k[i] == 2'd1) imm[i][12] = imm[i][11];
      if (k[i] == 2'd2) imm[i][0] = 1'b0;
    end
    bus.mem_wready = 1'b0;
    pulse_start();
    do_req(k[0], r[0], r[1], r[2], 3'(r[3]), 7'(r[0]), imm[0], acc);
    first = exp_q[0];
    set_req(k[1], r[1], r[2], r[3], 3'(r[0]), 7'(r[1]), imm[1]);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 1'b0 || bus.mem_wvalid !== 1'b1 || {bus.mem_waddr, bus.mem_wdata} !== first) begin
        n_fail++; $display("FAIL hold_%0d: got ready=%b wvalid=%b addr=%0d data=%h want 0/1/%0d/%h", i,
          bus.req_ready, bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, first.addr, first.data); end
      @(posedge clk); #1;
    end
    bus.mem_wready = 1'b1;
    do_req(k[1], r[1], r[2], r[3], 3'(r[0]), 7'(r[1]), imm[1], acc);
    do_req(k[2], r[2], r[3], r[0], 3'(r[1]), 7'(r[2]), imm[2], acc);
    do_req(k[3], r[3], r[0], r[1], 3'(r[2]), 7'(r[3]), imm[3], acc);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL sb_missing: no write, want addr=%0d data=%h", e.addr, e.data);
      end else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_fail++; $display("FAIL sb_bp: got addr=%0d data=%h want addr=%0d data=%h", g.addr, g.data, e.addr, e.data); end
      end
    end
    bus.req_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (full !== 1'b1 || count !== 11'd4 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got full=%b count=%0d ready=%b want 1/4/0", full, count, bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_start_discard();
    bit acc;
    bus.mem_wready = 1'b0;
    pulse_start();
    do_req(2'd3, 5'd9, 5'd8, 5'd7, 3'd1, 7'd0, 13'd0, acc);
    n_cmp++; if (bus.mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL pend_wvalid: got %b want 1", bus.mem_wvalid); end
    set_req(2'd0, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 13'd4);
    bus.req_valid = 1'b1;
    start = 1'b1;
    exp_q.delete();
    exp_ptr = '0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL start_blocks_req: got ready=%b want 0", bus.req_ready); end
    @(posedge clk); #1;
    start = 1'b0;
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.mem_wvalid !== 1'b0 || count !== '0) begin
      n_fail++; $display("FAIL start_discard: got wvalid=%b count=%0d want 0/0", bus.mem_wvalid, count); end
    bus.mem_wready = 1'b1;
    idle(2);
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL discard_extra: got %0d writes want 0", got_q.size()); end
    got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_rst_midstream();
    bit acc;
    wr_t g, e;
    bus.mem_wready = 1'b1;
    pulse_start();
    do_req(2'd0, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 13'd12, acc);
    do_req(2'd1, 5'd0, 5'd4, 5'd5, 3'd2, 7'd0, 13'h1FF0, acc);
    bus.mem_wready = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.mem_wvalid !== 1'b0 || bus.mem_waddr !== '0 || bus.mem_wdata !== 32'h0 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_bus: got wvalid=%b addr=%0d data=%h ready=%b want all 0",
        bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata, bus.req_ready); end
    n_cmp++; if (count !== '0 || full !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_status: got count=%0d full=%b err=%b want 0/0/0", count, full, err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL sb_missing: no write, want addr=%0d data=%h", e.addr, e.data);
      end else begin
        g = got_q.pop_front(); void'(got_cyc.pop_front());
        if (g !== e) begin n_fail++; $display("FAIL sb_rst: got addr=%0d data=%h want addr=%0d data=%h", g.addr, g.data, e.addr, e.data); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_extra: got %0d extra writes want 0", got_q.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_start_discard();
    test_rst_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
